code_lock_ctrl: RTL and testbench

// - Parametrised combination-lock controller: collects digit pulses, compares them to a stored code, and drives UNLOCK/ERROR/ALARM.
// - Generalises the fixed 5-state lock FSM with configurable code length, digit width, retry limit, timed states, idle timeout and admin code change.
// - Sits between the switch/button conditioning stage (one-cycle pulses in) and the display/LED drivers (levels out).

---
 rtl/code_lock_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// Combination-lock controller: collects digit pulses into an entry buffer, checks
// them against a stored code and sequences UNLOCK / ERROR / ALARM / code-change modes.
module code_lock_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] INIT_CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int ERR_CYC   = 1000,
  parameter int ALARM_CYC = 5000,
  parameter int UNLK_CYC  = 5000,
  parameter int IDLE_CYC  = 10000
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             digit_vld,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             ok,
  input  logic                             bksp,
  input  logic                             admin,
  output logic [2:0]                       state,
  output logic                             unlocked,
  output logic                             error,
  output logic                             alarm,
  output logic [$clog2(DIGITS+1)-1:0]      entry_cnt,
  output logic [DIGITS*DIGIT_W-1:0]        entry_buf,
  output logic [$clog2(MAX_TRIES+1)-1:0]   err_cnt,
  output logic                             code_upd
);
  localparam int CW   = $clog2(DIGITS+1);
  localparam int EW   = $clog2(MAX_TRIES+1);
  localparam int BW   = DIGITS*DIGIT_W;
  localparam int M1   = (ERR_CYC > ALARM_CYC) ? ERR_CYC : ALARM_CYC;
  localparam int M2   = (UNLK_CYC > IDLE_CYC) ? UNLK_CYC : IDLE_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int TW   = $clog2(MAXC+1);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0, S_INPUT = 3'd1, S_UNLOCK = 3'd2,
    S_ERROR = 3'd3, S_ALARM = 3'd4, S_ADMIN = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      code_q, code_d, buf_q, buf_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_m1;
  logic [EW-1:0]      errc_q, errc_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               upd_q, upd_d, unl_q, err_q, alm_q;
  logic               dv_q, ok_q, bk_q, adm_q;
  logic [DIGIT_W-1:0] dig_q;
  logic               ev_adm, ev_ok, ev_bk, ev_dig, full, acc;

  // Timer preload gives exactly N cycles of residence in a timed state.
  function automatic logic [TW-1:0] reload(state_t s);
    case (s)
      S_INPUT, S_ADMIN: reload = TW'(IDLE_CYC - 1);
      S_UNLOCK:         reload = TW'(UNLK_CYC - 1);
      S_ERROR:          reload = TW'(ERR_CYC - 1);
      S_ALARM:          reload = TW'(ALARM_CYC - 1);
      default:          reload = '0;
    endcase
  endfunction

  // Single winner per cycle; lower-priority pulses are dropped even when ignored.
  assign ev_adm = adm_q;
  assign ev_ok  = ok_q & ~adm_q;
  assign ev_bk  = bk_q & ~ok_q & ~adm_q;
  assign ev_dig = dv_q & ~bk_q & ~ok_q & ~adm_q;
  assign full   = (cnt_q == CW'(DIGITS));
  assign cnt_m1 = cnt_q - 1'b1;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    errc_d  = errc_q;
    upd_d   = 1'b0;
    acc     = 1'b0;
    tmr_d   = (tmr_q == '0) ? tmr_q : tmr_q - 1'b1;
    case (state_q)
      S_WAIT: begin
        if (ev_dig) begin
          buf_d = '0;
          buf_d[DIGIT_W-1:0] = dig_q;
          cnt_d   = CW'(1);
          state_d = S_INPUT;
        end
      end
      S_INPUT, S_ADMIN: begin
        if (ev_ok) begin
          if (state_q == S_INPUT) begin
            buf_d = '0;
            cnt_d = '0;
            if (full && buf_q == code_q) begin
              errc_d  = '0;
              state_d = S_UNLOCK;
            end else begin
              errc_d  = errc_q + 1'b1;
              state_d = (errc_d == EW'(MAX_TRIES)) ? S_ALARM : S_ERROR;
            end
          end else if (full) begin
            code_d  = buf_q;
            upd_d   = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end else if (ev_bk) begin
          if (cnt_q != '0) begin
            for (int i = 0; i < DIGITS; i++)
              if (CW'(i) == cnt_m1) buf_d[i*DIGIT_W +: DIGIT_W] = '0;
            cnt_d = cnt_m1;
            acc   = 1'b1;
            if (cnt_m1 == '0 && state_q == S_INPUT) state_d = S_WAIT;
          end else if (state_q == S_ADMIN) begin
            state_d = S_UNLOCK;
          end
        end else if (ev_dig && !full) begin
          for (int i = 0; i < DIGITS; i++)
            if (CW'(i) == cnt_q) buf_d[i*DIGIT_W +: DIGIT_W] = dig_q;
          cnt_d = cnt_q + 1'b1;
          acc   = 1'b1;
        end
        if (state_d == state_q) begin
          if (acc) tmr_d = TW'(IDLE_CYC - 1);
          else if (tmr_q == '0) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_UNLOCK: begin
        if (ev_adm) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_ADMIN;
        end else if (ev_ok || tmr_q == '0) begin
          state_d = S_WAIT;
        end
      end
      S_ERROR: if (tmr_q == '0) state_d = S_WAIT;
      S_ALARM: begin
        if (tmr_q == '0) begin
          errc_d  = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
    if (state_d != state_q) tmr_d = reload(state_d);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dv_q    <= 1'b0;
      dig_q   <= '0;
      ok_q    <= 1'b0;
      bk_q    <= 1'b0;
      adm_q   <= 1'b0;
      state_q <= S_WAIT;
      code_q  <= INIT_CODE;
      buf_q   <= '0;
      cnt_q   <= '0;
      errc_q  <= '0;
      tmr_q   <= '0;
      upd_q   <= 1'b0;
      unl_q   <= 1'b0;
      err_q   <= 1'b0;
      alm_q   <= 1'b0;
    end else begin
      dv_q    <= digit_vld;
      dig_q   <= digit;
      ok_q    <= ok;
      bk_q    <= bksp;
      adm_q   <= admin;
      state_q <= state_d;
      code_q  <= code_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      errc_q  <= errc_d;
      tmr_q   <= tmr_d;
      upd_q   <= upd_d;
      unl_q   <= (state_d == S_UNLOCK);
      err_q   <= (state_d == S_ERROR);
      alm_q   <= (state_d == S_ALARM);
    end
  end

  assign state     = state_q;
  assign unlocked  = unl_q;
  assign error     = err_q;
  assign alarm     = alm_q;
  assign entry_cnt = cnt_q;
  assign entry_buf = buf_q;
  assign err_cnt   = errc_q;
  assign code_upd  = upd_q;
endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed scenarios plus random pulses, every cycle compared
// against a queue-based behavioural model of the lock.
module tb_code_lock_ctrl;
  localparam int D = 4, MT = 3, ERRC = 1000, ALMC = 5000, UNLC = 5000, IDLC = 10000;
  localparam logic [15:0] INIT = 16'h1234;

  logic CLK = 1'b0, RESET = 1'b1, digit_vld = 1'b0, ok = 1'b0, bksp = 1'b0, admin = 1'b0;
  logic [3:0]  digit = '0;
  logic [2:0]  state, entry_cnt;
  logic        unlocked, error, alarm, code_upd;
  logic [15:0] entry_buf;
  logic [1:0]  err_cnt;

  code_lock_ctrl dut (
    .CLK(CLK), .RESET(RESET), .digit_vld(digit_vld), .digit(digit), .ok(ok),
    .bksp(bksp), .admin(admin), .state(state), .unlocked(unlocked), .error(error),
    .alarm(alarm), .entry_cnt(entry_cnt), .entry_buf(entry_buf), .err_cnt(err_cnt),
    .code_upd(code_upd)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state number, cycles spent in state, digits typed so far.
  typedef struct packed { logic dv; logic [3:0] d; logic o; logic b; logic a; } in_t;
  int   st, age, ec;
  int   q[$];
  int   mcode[D];
  logic mupd;
  in_t  h0, h1;

  function automatic int limit(int s);
    case (s)
      1, 5:    limit = IDLC;
      2:       limit = UNLC;
      3:       limit = ERRC;
      default: limit = ALMC;
    endcase
  endfunction

  task automatic mgo(input int s);
    st = s; age = 0;
  endtask

  task automatic mreset();
    logic [15:0] ic;
    ic = INIT;
    mgo(0); ec = 0; mupd = 1'b0; q.delete();
    for (int i = 0; i < D; i++) mcode[i] = int'(ic[i*4 +: 4]);
    h0 = '0; h1 = '0;
  endtask

  task automatic mstep(input in_t in);
    int   ev, s0;
    logic acc, match;
    mupd = 1'b0; acc = 1'b0; s0 = st;
    ev = in.a ? 4 : in.o ? 3 : in.b ? 2 : in.dv ? 1 : 0;
    case (st)
      0: if (ev == 1) begin q.delete(); q.push_back(int'(in.d)); mgo(1); end
      1, 5: begin
        if (ev == 3) begin
          if (st == 1) begin
            match = (q.size() == D);
            if (match) for (int i = 0; i < D; i++) if (q[i] != mcode[i]) match = 1'b0;
            q.delete();
            if (match) begin ec = 0; mgo(2); end
            else begin ec++; mgo(ec == MT ? 4 : 3); end
          end else if (q.size() == D) begin
            for (int i = 0; i < D; i++) mcode[i] = q[i];
            mupd = 1'b1; q.delete(); mgo(0);
          end
        end else if (ev == 2) begin
          if (q.size() > 0) begin
            void'(q.pop_back()); acc = 1'b1;
            if (st == 1 && q.size() == 0) mgo(0);
          end else if (st == 5) mgo(2);
        end else if (ev == 1 && q.size() < D) begin
          q.push_back(int'(in.d)); acc = 1'b1;
        end
        if (st == s0) begin
          if (acc) age = 0;
          else if (age == IDLC - 1) begin q.delete(); mgo(0); end
          else age++;
        end
      end
      2: begin
        if (ev == 4) begin q.delete(); mgo(5); end
        else if (ev == 3) mgo(0);
        else if (age == UNLC - 1) mgo(0);
        else age++;
      end
      default: begin
        if (age == limit(st) - 1) begin
          if (st == 4) ec = 0;
          mgo(0);
        end else age++;
      end
    endcase
  endtask

  task automatic mcheck();
    logic [15:0] e;
    e = '0;
    foreach (q[i]) e[i*4 +: 4] = q[i][3:0];
    chk("m_state", state, st);
    chk("m_unlocked", unlocked, st == 2);
    chk("m_error", error, st == 3);
    chk("m_alarm", alarm, st == 4);
    chk("m_entry_cnt", entry_cnt, q.size());
    chk("m_entry_buf", entry_buf, e);
    chk("m_err_cnt", err_cnt, ec);
    chk("m_code_upd", code_upd, mupd);
  endtask

  // One clock: model consumes the pulse driven two negedges ago, compare, drive new pulses.
  task automatic cyc(input logic dv, input int d, input logic o, input logic b, input logic a);
    in_t n;
    @(negedge CLK);
    mstep(h1);
    mcheck();
    n.dv = dv; n.d = d[3:0]; n.o = o; n.b = b; n.a = a;
    h1 = h0; h0 = n;
    digit_vld = dv; digit = d[3:0]; ok = o; bksp = b; admin = a;
  endtask

  task automatic key(input int d);  cyc(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic pok();             cyc(1'b0, 0, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle(input int n); repeat (n) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0); endtask

  task automatic wait_st(input int s, input int budget);
    int n;
    n = 0;
    while (state !== 3'(s) && n < budget) begin idle(1); n++; end
    chk("wait_state", state, s);
  endtask

  task automatic do_reset(input string tag);
    @(posedge CLK);
    #2;
    digit_vld = 1'b0; ok = 1'b0; bksp = 1'b0; admin = 1'b0;
    RESET = 1'b1;
    #1;
    chk({tag, "_state"}, state, 0);
    chk({tag, "_flags"}, {unlocked, error, alarm, code_upd}, 4'b0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_entry"}, {entry_cnt, entry_buf}, 19'h0);
    @(negedge CLK);
    RESET = 1'b0;
    mreset();
  endtask

  task automatic rand_cycle();
    int r, d;
    logic dv, o, b, a;
    r = $urandom_range(0, 99);
    d = $urandom_range(0, 15);
    dv = 1'b0; o = 1'b0; b = 1'b0; a = 1'b0;
    if (r < 40) begin
      dv = 1'b1;
      if (q.size() < D && $urandom_range(0, 3) != 0) d = mcode[q.size()];
    end else if (r < 47) o = 1'b1;
    else if (r < 52) b = 1'b1;
    else if (r < 56) a = 1'b1;
    else if (r >= 94) {dv, o, b, a} = 4'($urandom_range(0, 15));
    cyc(dv, d, o, b, a);
  endtask

  initial begin
    int n;
    mreset();
    do_reset("reset");

    // Stored code 16'h1234 holds digit 0 = 4, so the typed sequence is 4,3,2,1.
    key(4); key(3); key(2); key(1); pok();
    idle(1); chk("unlock_latency", unlocked, 0);
    idle(1); chk("unlock", unlocked, 1); chk("unlock_errcnt", err_cnt, 0);
    pok(); idle(2); chk("relock", state, 0);

    // Three wrong codes: ERROR, ERROR, ALARM for exactly ALARM_CYC cycles.
    for (int k = 1; k <= 3; k++) begin
      key(1); key(2); key(3); key(5); pok(); idle(2);
      chk("wrong_errcnt", err_cnt, k);
      if (k < 3) begin chk("wrong_error", error, 1); wait_st(0, ERRC + 10); end
    end
    wait_st(4, 10);
    n = 0;
    while (alarm === 1'b1 && n < ALMC + 100) begin idle(1); n++; end
    chk("alarm_cycles", n, ALMC);
    chk("alarm_exit_state", state, 0);
    chk("alarm_exit_errcnt", err_cnt, 0);

    // Typing the hex digits in reading order does not match.
    key(1); key(2); key(3); key(4); pok(); idle(2);
    chk("reversed_error", error, 1);
    wait_st(0, ERRC + 10);

    // Backspace and full-buffer drop.
    key(4); key(3); key(9); cyc(1'b0, 0, 1'b0, 1'b1, 1'b0); key(2); key(1); key(7); idle(2);
    chk("full_buf", entry_buf, 16'h1234);
    chk("full_cnt", entry_cnt, 4);
    pok(); idle(2); chk("bksp_unlock", unlocked, 1);

    // Code change in ADMIN.
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1); key(9); key(8); key(7); key(6); pok();
    idle(2); chk("code_upd_pulse", code_upd, 1); chk("code_upd_state", state, 0);
    idle(1); chk("code_upd_clear", code_upd, 0);
    key(9); key(8); key(7); key(6); pok(); idle(2); chk("new_code_unlock", unlocked, 1);
    pok(); idle(2);
    key(4); key(3); key(2); key(1); pok(); idle(2); chk("old_code_error", error, 1);
    wait_st(0, ERRC + 10);

    // ok + digit together: digit dropped, short entry is a wrong try.
    key(1); cyc(1'b1, 2, 1'b1, 1'b0, 1'b0); idle(2);
    chk("ok_digit_state", state, 3); chk("ok_digit_cnt", entry_cnt, 0); chk("ok_digit_errcnt", err_cnt, 2);
    wait_st(0, ERRC + 10);

    // Idle timeout.
    key(1); idle(IDLC - 10); chk("idle_still_input", state, 1);
    wait_st(0, 100);
    chk("idle_cnt", entry_cnt, 0); chk("idle_errcnt", err_cnt, 2);

    // Reset in ALARM, then in ADMIN; the code must come back to the initial value.
    key(1); pok(); idle(100); chk("pre_reset_alarm", alarm, 1);
    do_reset("rst_alarm");
    key(4); key(3); key(2); key(1); pok(); idle(2); chk("init_restored", unlocked, 1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1); key(5); key(5); idle(2); chk("pre_reset_admin", state, 5);
    do_reset("rst_admin");

    repeat (4000) rand_cycle();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
